kyber_rej_sampler: RTL and testbench
====================================

Name: kyber_rej_sampler

Overview:
- Rejection sampler (Kyber Parse / SampleNTT) sitting directly downstream of the Keccak core running SHAKE128.
- Consumes the 64-bit squeeze word stream and splits it into 12-bit candidates.
- Accepts candidates < Q and writes exactly N coefficients into the polynomial RAM write port.
- Applies ready/valid backpressure upstream; the Keccak controller stalls squeeze output while i_bytes_ready is low.

Parameters:
- Q, 3329, modulus; candidates >= Q are rejected.
- N, 256, coefficients per polynomial.
- BUF_BYTES, 16, byte FIFO depth; minimum 11.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; clears buffer and counter, begins sampling
- i_bytes  in  64  squeeze word; byte k = i_bytes[8k+7:8k], byte 0 oldest
- i_bytes_valid  in  1  i_bytes valid
- o_bytes_ready  out  1  word accepted when valid & ready
- o_we_a / o_we_b  out  1 each  coefficient write enables
- o_addr_a / o_addr_b  out  8 each  coefficient indices
- o_coef_a / o_coef_b  out  12 each  coefficient values
- o_busy  out  1  high in S_RUN
- o_done  out  1  one-cycle pulse after the N-th coefficient is written

Behaviour:
Reset:
- State S_IDLE, fill=0, cnt=0.
- All outputs 0, including o_bytes_ready.

FSM:
- S_IDLE -> S_RUN on i_start.
- S_RUN -> S_DONE on the cycle the N-th write is registered.
- S_DONE -> S_IDLE unconditionally.
- i_start in S_RUN or S_DONE: restart; fill=0, cnt=0, pending writes discarded, stay in or enter S_RUN.

Handshake:
- o_bytes_ready = (state==S_RUN) && (fill <= BUF_BYTES-8), combinational from registered state and fill.
- Words offered while ready is low are not consumed; upstream holds them.

Buffer:
- Byte FIFO, oldest byte at slot 0, fill 0..BUF_BYTES.

Per cycle in S_RUN, when fill >= 3 and cnt < N:
- Take b0, b1, b2 from slots 0..2.
- d1 = b0 + 256*(b1 & 0xF); d2 = (b1 >> 4) + 16*b2.
- Shift the FIFO down by 3.

Append and fill update:
- An accepted word is appended at slot (fill - consumed), where consumed is 3 or 0.
- Next fill = fill - consumed + 8*accepted.
- Worst case fill is 13; it never exceeds BUF_BYTES.

Acceptance:
- acc1 = (d1 < Q) && (cnt < N).
- acc2 = (d2 < Q) && (cnt + acc1 < N).
- The second candidate of the triplet that completes N is dropped.

Write port (registered, one cycle after the triplet is taken):
- o_we_a = acc1 | acc2.
- o_coef_a = acc1 ? d1 : d2; o_addr_a = cnt[7:0].
- o_we_b = acc1 & acc2; o_coef_b = d2; o_addr_b = cnt + 1.
- cnt += acc1 + acc2; cnt is 9 bits.

Latency:
- A word accepted at edge t is in the buffer at t+1.
- Its first triplet produces a write at edge t+2.

Completion and idle:
- o_done pulses in the S_DONE cycle.
- The remaining buffered bytes are discarded; fill is cleared on S_DONE.
- In S_IDLE all write enables are 0; i_bytes_valid is ignored.

Reset mid-operation:
- Immediate return to reset values.
- No further writes or o_done.

Test Plan:
1. i_start, then continuous all-zero words with valid held high -> 256 writes of 0, addr pairs (0,1)..(254,255), o_done after 48 accepted words; o_bytes_ready toggles and no byte is lost.
2. Triplet 0x01,0x23,0x45 -> o_coef_a=769 at addr 0, o_coef_b=1106 at addr 1, both we high.
3. Boundary triplet with d1=3328 (0x00,0x0D,..) accepted; d1=3329 (0x01,0x0D,..) rejected; all-0xFF words -> no writes, cnt stays 0, o_busy stays high.
4. Drive cnt to 255, then a triplet with both candidates valid -> only port a writes (addr 255), o_we_b=0, o_done next cycle, o_bytes_ready=0 afterwards.
5. i_bytes_valid gapped randomly against a reference model -> identical coefficient sequence regardless of gaps; fill never exceeds 16.
6. Assert i_rstn low at cnt=100, then i_start again -> outputs 0 during reset; the new run restarts at addr 0 with an empty buffer.

Source files
------------

// File: rtl/kyber_rej_sampler.sv
// Kyber SampleNTT rejection sampler: splits SHAKE128 squeeze words into 12-bit candidates
// and writes up to two accepted coefficients per cycle into the polynomial RAM.
module kyber_rej_sampler #(
    parameter int unsigned Q         = 3329,
    parameter int unsigned N         = 256,
    parameter int unsigned BUF_BYTES = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [63:0] i_bytes,
    input  logic        i_bytes_valid,
    output logic        o_bytes_ready,
    output logic        o_we_a,
    output logic        o_we_b,
    output logic [7:0]  o_addr_a,
    output logic [7:0]  o_addr_b,
    output logic [11:0] o_coef_a,
    output logic [11:0] o_coef_b,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned FW = $clog2(BUF_BYTES + 1);
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned BW = 8 * BUF_BYTES;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic            we_a_q, we_a_d, we_b_q, we_b_d;
    logic [7:0]      addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [11:0]     coef_a_q, coef_a_d, coef_b_q, coef_b_d;

    logic            take, accept, acc1, acc2;
    logic [11:0]     d1, d2;
    logic [FW-1:0]   base;
    logic [BW-1:0]   shifted, word_ext, word_mask;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start pulse restarts from any state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StRun;
            StRun:   if (cnt_q == CW'(N)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (i_start) begin
            state_d = StRun;
        end
    end

    // Output logic
    always_comb begin
        o_busy        = (state_q == StRun);
        o_done        = (state_q == StDone);
        o_bytes_ready = (state_q == StRun) && (fill_q <= FW'(BUF_BYTES - 8));
    end

    assign accept = i_bytes_valid && o_bytes_ready;
    assign take   = (state_q == StRun) && (fill_q >= FW'(3)) && (cnt_q < CW'(N));

    assign d1   = {buf_q[11:8], buf_q[7:0]};
    assign d2   = {buf_q[23:16], buf_q[15:12]};
    assign acc1 = take && (d1 < 12'(Q));
    // The second candidate must not overrun N when the first one lands on the last slot
    assign acc2 = take && (d2 < 12'(Q)) && ((cnt_q + CW'(acc1)) < CW'(N));

    // Byte FIFO: drop the consumed triplet, then drop the new word in right behind what remains
    always_comb begin
        base      = take ? (fill_q - FW'(3)) : fill_q;
        shifted   = take ? (buf_q >> 24) : buf_q;
        word_ext  = BW'(i_bytes) << {base, 3'b000};
        word_mask = BW'({64{1'b1}}) << {base, 3'b000};
        buf_d     = accept ? ((shifted & ~word_mask) | word_ext) : shifted;
        fill_d    = base + (accept ? FW'(8) : FW'(0));
        if (i_start || (state_q == StDone)) begin
            fill_d = '0;
        end
    end

    always_comb begin
        cnt_d    = i_start ? '0 : (cnt_q + CW'(acc1) + CW'(acc2));
        we_a_d   = (acc1 || acc2) && !i_start;
        we_b_d   = acc1 && acc2 && !i_start;
        addr_a_d = we_a_d ? cnt_q[7:0] : 8'd0;
        coef_a_d = we_a_d ? (acc1 ? d1 : d2) : 12'd0;
        addr_b_d = we_b_d ? (cnt_q[7:0] + 8'd1) : 8'd0;
        coef_b_d = we_b_d ? d2 : 12'd0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fill_q   <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            coef_a_q <= '0;
            coef_b_q <= '0;
        end else begin
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            coef_a_q <= coef_a_d;
            coef_b_q <= coef_b_d;
        end
    end

    assign o_we_a   = we_a_q;
    assign o_we_b   = we_b_q;
    assign o_addr_a = addr_a_q;
    assign o_addr_b = addr_b_q;
    assign o_coef_a = coef_a_q;
    assign o_coef_b = coef_b_q;

endmodule

// File: tb/tb_kyber_rej_sampler.sv
// Bench for kyber_rej_sampler: hand vectors for single triplets plus byte-stream runs checked
// against a queue-based Parse model.
module tb_kyber_rej_sampler;

    localparam int Q = 3329;
    localparam int N = 256;
    localparam int BUF_BYTES = 16;

    logic        clk = 1'b0;
    logic        rstn, start, valid;
    logic [63:0] bytes;
    logic        ready, we_a, we_b, busy, done;
    logic [7:0]  addr_a, addr_b;
    logic [11:0] coef_a, coef_b;

    kyber_rej_sampler #(.Q(Q), .N(N), .BUF_BYTES(BUF_BYTES)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_start       (start),
        .i_bytes       (bytes),
        .i_bytes_valid (valid),
        .o_bytes_ready (ready),
        .o_we_a        (we_a),
        .o_we_b        (we_b),
        .o_addr_a      (addr_a),
        .o_addr_b      (addr_b),
        .o_coef_a      (coef_a),
        .o_coef_b      (coef_b),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [44:0] all_outs();
        return {ready, we_a, we_b, addr_a, addr_b, coef_a, coef_b, busy, done};
    endfunction

    // Stream under test and the reference model's expected coefficients
    logic [63:0] words [0:127];
    int          nwords;
    int          exp_q[$];
    logic [7:0]  bq[$];

    task automatic pack_bytes();
        while (bq.size() % 8 != 0) bq.push_back(8'h00);
        nwords = bq.size() / 8;
        for (int w = 0; w < nwords; w++)
            for (int k = 0; k < 8; k++) words[w][8*k +: 8] = bq[8*w + k];
    endtask

    // Parse: every 3 bytes give two 12-bit candidates, keep those below Q until N are held
    task automatic build_model();
        int stream[$];
        exp_q.delete();
        for (int w = 0; w < nwords; w++)
            for (int k = 0; k < 8; k++) stream.push_back(int'(words[w][8*k +: 8]));
        for (int i = 0; i + 2 < stream.size() && exp_q.size() < N; i += 3) begin
            int c1, c2;
            c1 = stream[i] + 256 * (stream[i+1] % 16);
            c2 = (stream[i+1] / 16) + 16 * stream[i+2];
            if (c1 < Q) exp_q.push_back(c1);
            if (c2 < Q && exp_q.size() < N) exp_q.push_back(c2);
        end
    endtask

    // Observations of one run
    int got_addr[$], got_coef[$];
    int n_dual, done_cnt, done_cyc, last_wr_cyc, rdy_after_done, max_fill, words_acc;
    logic       last_we_b;
    logic [7:0] last_addr_a;
    logic [11:0] last_coef_a;

    task automatic reset_hold(input string name);
        rstn = 1'b0;
        #1 check({name, "_async"}, 64'(all_outs()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({name, "_held"}, 64'(all_outs()), 64'd0);
        end
        rstn = 1'b1;
    endtask

    task automatic run_stream(input int prob, input int rst_at);
        int idx = 0;
        int cyc = 0;
        got_addr.delete(); got_coef.delete();
        n_dual = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -10;
        rdy_after_done = 0; max_fill = 0; words_acc = 0;
        start = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 4000 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
            bytes = (idx < nwords) ? words[idx] : 64'd0;
            valid = (idx < nwords) && (int'($urandom_range(99)) < prob);
            if (we_a) begin
                got_addr.push_back(int'(addr_a)); got_coef.push_back(int'(coef_a));
                last_wr_cyc = cyc; last_we_b = we_b; last_addr_a = addr_a; last_coef_a = coef_a;
            end
            if (we_b) begin
                got_addr.push_back(int'(addr_b)); got_coef.push_back(int'(coef_b));
                n_dual++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && ready) rdy_after_done++;
            if (int'(dut.fill_q) > max_fill) max_fill = int'(dut.fill_q);
            if (valid && ready) begin
                idx++;
                words_acc++;
            end
            if (rst_at >= 0 && got_addr.size() >= rst_at) begin
                valid = 1'b0;
                reset_hold("rst_mid");
                for (int i = 0; i < 5; i++) begin
                    valid = 1'b1; bytes = 64'd0;
                    @(posedge clk); #1;
                    check("idle_after_rst", 64'(all_outs()), 64'd0);
                end
                valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        valid = 1'b0;
    endtask

    task automatic check_run(input string name);
        int n;
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_ncoef"}, 64'(got_addr.size()), 64'(N));
        n = (got_addr.size() < exp_q.size()) ? got_addr.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr[%0d]", name, i), 64'(got_addr[i]), 64'(i));
            check($sformatf("%s_coef[%0d]", name, i), 64'(got_coef[i]), 64'(exp_q[i]));
        end
        check({name, "_done_timing"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
        check({name, "_ready_after_done"}, 64'(rdy_after_done), 64'd0);
        check({name, "_fill_bound"}, 64'(max_fill <= BUF_BYTES), 64'd1);
    endtask

    typedef struct {
        logic [63:0] word;
        logic        we_a, we_b;
        logic [11:0] coef_a, coef_b;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FF45_2301, 1'b1, 1'b1, 12'd769,  12'd1106};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_0D00, 1'b1, 1'b0, 12'd3328, 12'd0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_0D01, 1'b0, 1'b0, 12'd0,    12'd0};
        vecs[3] = '{64'hFFFF_FFFF_FF00_0D01, 1'b1, 1'b0, 12'd0,    12'd0};
        vecs[4] = '{64'hFFFF_FFFF_FFD0_0005, 1'b1, 1'b1, 12'd5,    12'd3328};
        vecs[5] = '{64'hFFFF_FFFF_FFD0_1005, 1'b1, 1'b0, 12'd5,    12'd0};

        start = 1'b0; valid = 1'b0; bytes = 64'd0;
        reset_hold("reset");
        @(posedge clk); #1;
        check("post_reset_outputs", 64'(all_outs()), 64'd0);

        // Single-triplet vectors: write appears two edges after the word is accepted
        for (int v = 0; v < 6; v++) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; bytes = vecs[v].word; valid = 1'b1;
            check($sformatf("vec%0d_ready", v), 64'(ready), 64'd1);
            @(posedge clk); #1;
            valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("vec%0d_we_a", v), 64'(we_a), 64'(vecs[v].we_a));
            check($sformatf("vec%0d_we_b", v), 64'(we_b), 64'(vecs[v].we_b));
            if (vecs[v].we_a) begin
                check($sformatf("vec%0d_coef_a", v), 64'(coef_a), 64'(vecs[v].coef_a));
                check($sformatf("vec%0d_addr_a", v), 64'(addr_a), 64'd0);
            end
            if (vecs[v].we_b) begin
                check($sformatf("vec%0d_coef_b", v), 64'(coef_b), 64'(vecs[v].coef_b));
                check($sformatf("vec%0d_addr_b", v), 64'(addr_b), 64'd1);
            end
        end

        // All 0xFF: nothing accepted, sampler keeps running
        begin
            int wr = 0, idle = 0, dn = 0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; bytes = '1; valid = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (we_a || we_b) wr++;
                if (!busy) idle++;
                if (done) dn++;
            end
            valid = 1'b0;
            check("ff_writes", 64'(wr), 64'd0);
            check("ff_busy_low", 64'(idle), 64'd0);
            check("ff_done", 64'(dn), 64'd0);
        end

        // All-zero stream with valid held high
        bq.delete();
        repeat (60 * 8) bq.push_back(8'h00);
        pack_bytes(); build_model();
        run_stream(100, -1);
        check_run("zeros");
        check("zeros_dual_writes", 64'(n_dual), 64'd128);
        check("zeros_words_used", 64'(words_acc >= 48), 64'd1);

        // cnt reaches 255, then a triplet with two valid candidates
        bq.delete();
        bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'hFF);
        repeat (127 * 3) bq.push_back(8'h00);
        bq.push_back(8'h01); bq.push_back(8'h23); bq.push_back(8'h45);
        pack_bytes(); build_model();
        run_stream(100, -1);
        check_run("last");
        check("last_we_b", 64'(last_we_b), 64'd0);
        check("last_addr_a", 64'(last_addr_a), 64'd255);
        check("last_coef_a", 64'(last_coef_a), 64'd769);

        // Random bytes, same stream with and without valid gaps
        for (int r = 0; r < 2; r++) begin
            nwords = 100;
            for (int w = 0; w < nwords; w++) words[w] = {$urandom, $urandom};
            build_model();
            run_stream(100, -1);
            check_run($sformatf("rand%0d_full", r));
            run_stream(35 + 30 * r, -1);
            check_run($sformatf("rand%0d_gap", r));
        end

        // Reset in the middle of a run, then a fresh run from address 0
        bq.delete();
        repeat (60 * 8) bq.push_back(8'h00);
        pack_bytes();
        run_stream(100, 100);
        nwords = 100;
        for (int w = 0; w < nwords; w++) words[w] = {$urandom, $urandom};
        build_model();
        run_stream(60, -1);
        check_run("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
